// File: rtl/apb2axi_burst_write_builder.sv
// ---------------------------------------------------------------------------
// apb2axi_burst_write_builder
//
// AXI write-issue engine for the APB2AXI bridge. Pops one write command
// {id, size, len, addr} from the command FIFO and issues the AW burst
// address. It streams len+1 W beats from the write-data FIFO at the same
// time, then tracks outstanding B responses. B responses pass straight
// through to the upstream done channel.
//
// Ports
//   aclk, aresetn        clock, asynchronous active-low reset
//   cmd_valid/ready/data command FIFO pop interface
//   wd_valid/ready/data/strb  write-data FIFO pop interface
//   aw* / w* / b*        AXI4 write address, data and response channels
//   done_valid/ready/id/resp  completed write status to the APB side
//   outstanding          AW-accepted writes still waiting for B
//   err_unexp_b          sticky flag: B accepted while nothing outstanding
// ---------------------------------------------------------------------------
module apb2axi_burst_write_builder #(
  parameter int unsigned AXI_ADDR_W      = 32,
  parameter int unsigned AXI_DATA_W      = 64,
  parameter int unsigned AXI_ID_W        = 4,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned CMD_W           = AXI_ID_W + 3 + 4 + AXI_ADDR_W
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  // command FIFO
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [CMD_W-1:0]        cmd_data,
  // write-data FIFO
  input  logic                    wd_valid,
  output logic                    wd_ready,
  input  logic [AXI_DATA_W-1:0]   wd_data,
  input  logic [AXI_DATA_W/8-1:0] wd_strb,
  // AXI AW
  output logic [AXI_ID_W-1:0]     awid,
  output logic [AXI_ADDR_W-1:0]   awaddr,
  output logic [3:0]              awlen,
  output logic [2:0]              awsize,
  output logic [1:0]              awburst,
  output logic                    awlock,
  output logic [3:0]              awcache,
  output logic [2:0]              awprot,
  output logic                    awvalid,
  input  logic                    awready,
  // AXI W
  output logic [AXI_DATA_W-1:0]   wdata,
  output logic [AXI_DATA_W/8-1:0] wstrb,
  output logic                    wlast,
  output logic                    wvalid,
  input  logic                    wready,
  // AXI B
  input  logic [AXI_ID_W-1:0]     bid,
  input  logic [1:0]              bresp,
  input  logic                    bvalid,
  output logic                    bready,
  // completion status upstream
  output logic                    done_valid,
  output logic [AXI_ID_W-1:0]     done_id,
  output logic [1:0]              done_resp,
  input  logic                    done_ready,
  // status
  output logic [3:0]              outstanding,
  output logic                    err_unexp_b
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACTIVE  = 2'd1,
    DRAIN_W = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;

  logic [AXI_ID_W-1:0]     r_id;
  logic [2:0]              r_size;
  logic [3:0]              r_len;
  logic [AXI_ADDR_W-1:0]   r_addr;
  logic [3:0]              r_beat_cnt;
  logic                    r_aw_done;
  logic [3:0]              r_outstanding;
  logic                    r_err_unexp_b;

  logic                    w_full;
  logic                    w_cmd_ready;
  logic                    w_awvalid;
  logic                    w_wvalid;
  logic                    w_wd_ready;
  logic                    w_wlast;
  logic                    w_cmd_pop;
  logic                    w_aw_hs;
  logic                    w_w_hs;
  logic                    w_b_hs;
  logic                    w_b_dec;

  assign w_full = (r_outstanding >= 4'(MAX_OUTSTANDING));

  // ------------------------------------------------------------------------
  // Next-state and channel control
  // ------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_cmd_ready = 1'b0;
    w_awvalid   = 1'b0;
    w_wvalid    = 1'b0;
    w_wd_ready  = 1'b0;
    w_wlast     = 1'b0;
    unique case (r_state)
      IDLE: begin
        // cmd_ready is gated by aresetn so it drops as soon as reset asserts
        w_cmd_ready = aresetn && !w_full;
        if (cmd_valid && w_cmd_ready) begin
          w_state_nxt = ACTIVE;
        end
      end
      ACTIVE: begin
        w_awvalid  = !r_aw_done;
        w_wvalid   = wd_valid;
        w_wd_ready = wready;
        w_wlast    = (r_beat_cnt == r_len);
        if (wd_valid && wready && w_wlast) begin
          // AW already taken, or taken on this same edge, finishes the burst
          w_state_nxt = (r_aw_done || awready) ? IDLE : DRAIN_W;
        end
      end
      DRAIN_W: begin
        w_awvalid = 1'b1;
        if (awready) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign w_cmd_pop = cmd_valid && w_cmd_ready;
  assign w_aw_hs   = w_awvalid && awready;
  assign w_w_hs    = w_wvalid && wready;
  assign w_b_hs    = bvalid && done_ready;
  // a B with nothing outstanding is flagged, never counted
  assign w_b_dec   = w_b_hs && (r_outstanding != '0);

  // ------------------------------------------------------------------------
  // State, command capture, beat/outstanding tracking
  // ------------------------------------------------------------------------
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state       <= IDLE;
      r_id          <= '0;
      r_size        <= '0;
      r_len         <= '0;
      r_addr        <= '0;
      r_beat_cnt    <= '0;
      r_aw_done     <= 1'b0;
      r_outstanding <= '0;
      r_err_unexp_b <= 1'b0;
    end else begin
      r_state <= w_state_nxt;

      if (w_cmd_pop) begin
        r_id       <= cmd_data[CMD_W-1 -: AXI_ID_W];
        r_size     <= cmd_data[AXI_ADDR_W+4 +: 3];
        r_len      <= cmd_data[AXI_ADDR_W +: 4];
        r_addr     <= cmd_data[AXI_ADDR_W-1:0];
        r_beat_cnt <= '0;
        r_aw_done  <= 1'b0;
      end else begin
        if (w_w_hs) begin
          r_beat_cnt <= r_beat_cnt + 4'd1;
        end
        if (w_aw_hs) begin
          r_aw_done <= 1'b1;
        end
      end

      if (w_aw_hs && !w_b_dec) begin
        r_outstanding <= r_outstanding + 4'd1;
      end else if (!w_aw_hs && w_b_dec) begin
        r_outstanding <= r_outstanding - 4'd1;
      end

      if (w_b_hs && (r_outstanding == '0)) begin
        r_err_unexp_b <= 1'b1;
      end
    end
  end

  // ------------------------------------------------------------------------
  // Outputs
  // ------------------------------------------------------------------------
  assign cmd_ready   = w_cmd_ready;

  assign awid        = r_id;
  assign awaddr      = r_addr;
  assign awlen       = r_len;
  assign awsize      = r_size;
  assign awburst     = 2'b01;
  assign awlock      = 1'b0;
  assign awcache     = 4'b0011;
  assign awprot      = 3'b000;
  assign awvalid     = w_awvalid;

  assign wvalid      = w_wvalid;
  assign wd_ready    = w_wd_ready;
  assign wdata       = wd_data;
  assign wstrb       = wd_strb;
  assign wlast       = w_wlast;

  assign bready      = done_ready;
  assign done_valid  = bvalid;
  assign done_id     = bid;
  assign done_resp   = bresp;

  assign outstanding = r_outstanding;
  assign err_unexp_b = r_err_unexp_b;

endmodule
